nor_stimulus_gen: RTL and testbench

Synchronous stimulus source that drives the four inputs a, b, c, d of the four-input NOR gate stage in hardware.
It replaces the free-running delay toggles used in simulation with clock-derived waveforms.
Mode 0 gives four independent square waves with programmable half-periods.
Mode 1 gives a one-shot exhaustive sweep of all 16 input combinations, with busy/done status for a downstream checker.

---
 rtl/nor_stimulus_gen.sv | 175 +++++++++++++++++
 tb/tb_nor_stimulus_gen.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/nor_stimulus_gen.sv
// nor_stimulus_gen: clock-derived stimulus for the four-input NOR stage.
// Mode 0 produces four independent square waves, one per input.
// Mode 1 produces a one-shot sweep of all 16 input vectors.
// The sweep reports busy/done status to a downstream checker.
module nor_stimulus_gen #(
    parameter int unsigned CNT_W = 8,
    parameter int unsigned HP_A  = 10,
    parameter int unsigned HP_B  = 7,
    parameter int unsigned HP_C  = 5,
    parameter int unsigned HP_D  = 1,
    parameter int unsigned DWELL = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic mode,
    input  logic start,
    output logic a,
    output logic b,
    output logic c,
    output logic d,
    output logic busy,
    output logic done
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SWEEP = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ZERO   = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL - 1);

    // Terminal count per channel; bit 3 of the vector is a, bit 0 is d.
    function automatic logic [CNT_W-1:0] hp_limit(input logic [1:0] idx);
        logic [CNT_W-1:0] lim;
        case (idx)
            2'd3:    lim = CNT_W'(HP_A - 1);
            2'd2:    lim = CNT_W'(HP_B - 1);
            2'd1:    lim = CNT_W'(HP_C - 1);
            2'd0:    lim = CNT_W'(HP_D - 1);
            default: lim = CNT_ZERO;
        endcase
        return lim;
    endfunction

    state_t           state_r, state_s;
    logic [3:0]       vec_r, vec_s;
    logic [CNT_W-1:0] cnt_r [0:3];
    logic [CNT_W-1:0] cnt_s [0:3];
    logic [CNT_W-1:0] dwell_r, dwell_s;
    logic             busy_r, busy_s;
    logic             done_r, done_s;
    logic             mode_prev_r;

    // Next-state and next-output computation for the whole block.
    always_comb begin
        state_s = state_r;
        vec_s   = vec_r;
        cnt_s   = cnt_r;
        dwell_s = dwell_r;
        busy_s  = busy_r;
        done_s  = 1'b0;

        case (state_r)
            ST_IDLE: begin
                busy_s = 1'b0;
                if (mode != mode_prev_r) begin
                    // A mode change restarts every waveform from a known phase.
                    vec_s   = 4'b0000;
                    dwell_s = CNT_ZERO;
                    for (int i = 0; i < 4; i++) begin
                        cnt_s[i] = CNT_ZERO;
                    end
                end else if (mode == 1'b0) begin
                    if (en) begin
                        for (int i = 0; i < 4; i++) begin
                            if (cnt_r[i] == hp_limit(2'(i))) begin
                                cnt_s[i] = CNT_ZERO;
                                vec_s[i] = ~vec_r[i];
                            end else begin
                                cnt_s[i] = cnt_r[i] + CNT_ONE;
                            end
                        end
                    end else begin
                        vec_s = vec_r;
                    end
                end else begin
                    vec_s = 4'b0000;
                    if (en && start) begin
                        // Free-run counters are cleared so a later mode-0 run starts cleanly.
                        state_s = ST_SWEEP;
                        dwell_s = CNT_ZERO;
                        busy_s  = 1'b1;
                        for (int i = 0; i < 4; i++) begin
                            cnt_s[i] = CNT_ZERO;
                        end
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
            end

            ST_SWEEP: begin
                busy_s = 1'b1;
                if (en) begin
                    if (dwell_r == DWELL_LAST) begin
                        dwell_s = CNT_ZERO;
                        if (vec_r == 4'b1111) begin
                            state_s = ST_DONE;
                            vec_s   = 4'b0000;
                            busy_s  = 1'b0;
                            done_s  = 1'b1;
                        end else begin
                            vec_s = vec_r + 4'b0001;
                        end
                    end else begin
                        dwell_s = dwell_r + CNT_ONE;
                    end
                end else begin
                    dwell_s = dwell_r;
                end
            end

            ST_DONE: begin
                state_s = ST_IDLE;
                vec_s   = 4'b0000;
                busy_s  = 1'b0;
                done_s  = 1'b0;
            end

            default: begin
                state_s = ST_IDLE;
                vec_s   = 4'b0000;
                busy_s  = 1'b0;
                done_s  = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            vec_r       <= 4'b0000;
            dwell_r     <= CNT_ZERO;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            mode_prev_r <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                cnt_r[i] <= CNT_ZERO;
            end
        end else begin
            state_r     <= state_s;
            vec_r       <= vec_s;
            dwell_r     <= dwell_s;
            busy_r      <= busy_s;
            done_r      <= done_s;
            mode_prev_r <= mode;
            for (int i = 0; i < 4; i++) begin
                cnt_r[i] <= cnt_s[i];
            end
        end
    end

    assign a    = vec_r[3];
    assign b    = vec_r[2];
    assign c    = vec_r[1];
    assign d    = vec_r[0];
    assign busy = busy_r;
    assign done = done_r;

endmodule

// File: tb/tb_nor_stimulus_gen.sv
// Testbench for nor_stimulus_gen.
// It uses a time-based reference model plus directed literal expectations.
module tb_nor_stimulus_gen;

    localparam int HP_A  = 10;
    localparam int HP_B  = 7;
    localparam int HP_C  = 5;
    localparam int HP_D  = 1;
    localparam int DWELL = 4;

    localparam int P_IDLE  = 0;
    localparam int P_SWEEP = 1;
    localparam int P_DONE  = 2;

    logic clk;
    logic rst_n;
    logic en;
    logic mode;
    logic start;
    logic a, b, c, d, busy, done;

    int check_cnt = 0;
    int err_cnt   = 0;

    nor_stimulus_gen #(
        .CNT_W(8), .HP_A(HP_A), .HP_B(HP_B), .HP_C(HP_C), .HP_D(HP_D), .DWELL(DWELL)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .start(start),
        .a(a), .b(b), .c(c), .d(d), .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        check_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Reference model: the phase plus the number of enabled edges elapsed in it.
    int m_phase     = P_IDLE;
    int m_kfree     = 0;
    int m_ksw       = 0;
    logic m_mode_prev = 1'b0;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_phase     <= P_IDLE;
            m_kfree     <= 0;
            m_ksw       <= 0;
            m_mode_prev <= 1'b0;
        end else begin
            m_mode_prev <= mode;
            case (m_phase)
                P_IDLE: begin
                    if (mode != m_mode_prev) m_kfree <= 0;
                    else if (!mode) begin
                        if (en) m_kfree <= m_kfree + 1;
                    end else if (en && start) begin
                        m_phase <= P_SWEEP;
                        m_ksw   <= 0;
                        m_kfree <= 0;
                    end
                end
                P_SWEEP: begin
                    if (en) begin
                        m_ksw <= m_ksw + 1;
                        if (m_ksw + 1 == 16 * DWELL) m_phase <= P_DONE;
                    end
                end
                default: m_phase <= P_IDLE;
            endcase
        end
    end

    // A square wave of half-period hp has toggled floor(k/hp) times after k enabled edges.
    function automatic logic [3:0] free_vec(input int k);
        return {((k / HP_A) % 2) == 1, ((k / HP_B) % 2) == 1,
                ((k / HP_C) % 2) == 1, ((k / HP_D) % 2) == 1};
    endfunction

    // Compare DUT outputs against the model on every falling edge.
    always @(negedge clk) begin
        logic [3:0] exp_vec;
        logic       exp_busy;
        logic       exp_done;
        exp_vec  = 4'b0000;
        exp_busy = 1'b0;
        exp_done = 1'b0;
        if (m_phase == P_IDLE) begin
            if (m_mode_prev == 1'b0) exp_vec = free_vec(m_kfree);
        end else if (m_phase == P_SWEEP) begin
            exp_vec  = 4'(m_ksw / DWELL);
            exp_busy = 1'b1;
        end else begin
            exp_done = 1'b1;
        end
        chk("model_vec",  32'({a, b, c, d}), 32'(exp_vec));
        chk("model_busy", 32'(busy), 32'(exp_busy));
        chk("model_done", 32'(done), 32'(exp_done));
    end

    task automatic wait_done(input int budget, output int waited);
        waited = 0;
        while (done !== 1'b1 && waited < budget) begin
            step(1);
            waited++;
        end
        chk("done_seen", 32'(done), 32'd1);
    endtask

    task automatic reset_pulse();
        rst_n = 1'b0;
        step(1);
        rst_n = 1'b1;
    endtask

    initial begin
        int w;
        int seen;
        rst_n = 1'b0;
        en    = 1'b1;
        mode  = 1'b0;
        start = 1'b0;

        // Reset and default free-run waveforms.
        step(3);
        chk("reset_outs", 32'({a, b, c, d, busy, done}), 32'd0);
        rst_n = 1'b1;
        step(5);
        chk("free_e5", 32'({a, b, c, d}), 32'h3);
        step(5);
        chk("free_e10", 32'({a, b, c, d}), 32'hC);

        // Enable freeze in mode 0.
        reset_pulse();
        step(12);
        chk("freeze_e12", 32'({a, b, c, d}), 32'hC);
        en = 1'b0;
        step(6);
        chk("freeze_hold", 32'({a, b, c, d}), 32'hC);
        en = 1'b1;
        step(7);
        chk("freeze_e19", 32'({a, b, c, d}), 32'hB);
        step(1);
        chk("freeze_a_edge26", 32'({a, b, c, d}), 32'h0);

        // Mode 0 run with an ignored start, then switch to mode 1.
        reset_pulse();
        step(6);
        start = 1'b1;
        step(1);
        start = 1'b0;
        step(6);
        chk("mode0_e13", 32'({a, b, c, d, busy}), 32'h1A);
        mode = 1'b1;
        step(1);
        chk("mode_switch", 32'({a, b, c, d, busy, done}), 32'd0);
        step(5);
        chk("mode1_idle", 32'({a, b, c, d, busy, done}), 32'd0);
        en    = 1'b0;
        start = 1'b1;
        step(1);
        start = 1'b0;
        en    = 1'b1;
        chk("start_en0_ignored", 32'(busy), 32'd0);
        step(2);
        chk("start_en0_still_idle", 32'(busy), 32'd0);

        // Full sweep.
        start = 1'b1;
        step(1);
        start = 1'b0;
        chk("sweep_start", 32'({a, b, c, d, busy}), 32'h01);
        step(20);
        chk("sweep_0101_first", 32'({a, b, c, d, busy}), 32'h0B);
        step(3);
        chk("sweep_0101_last", 32'({a, b, c, d}), 32'h5);
        step(1);
        chk("sweep_0110", 32'({a, b, c, d}), 32'h6);
        wait_done(100, w);
        chk("done_latency", 32'(w), 32'd40);
        chk("done_state", 32'({a, b, c, d, busy, done}), 32'h01);
        step(1);
        chk("after_done", 32'({a, b, c, d, busy, done}), 32'd0);

        // Sweep pause plus ignored mid-sweep start.
        start = 1'b1;
        step(1);
        start = 1'b0;
        step(25);
        chk("pause_at_0110", 32'({a, b, c, d}), 32'h6);
        en = 1'b0;
        step(3);
        chk("pause_hold", 32'({a, b, c, d, busy}), 32'h0D);
        en = 1'b1;
        step(1);
        start = 1'b1;
        step(1);
        start = 1'b0;
        chk("mid_start_ignored", 32'({a, b, c, d, busy}), 32'h0D);
        wait_done(100, w);
        chk("paused_done_latency", 32'(w), 32'd37);
        start = 1'b1;
        step(1);
        start = 1'b0;
        chk("start_in_done_ignored", 32'(busy), 32'd0);
        step(2);
        chk("idle_after_done_start", 32'(busy), 32'd0);

        // Reset in the middle of a sweep.
        start = 1'b1;
        step(1);
        start = 1'b0;
        step(41);
        chk("sweep_1010", 32'({a, b, c, d, busy}), 32'h15);
        rst_n = 1'b0;
        step(1);
        rst_n = 1'b1;
        chk("reset_mid_sweep", 32'({a, b, c, d, busy, done}), 32'd0);
        seen = 0;
        for (int i = 0; i < 80; i++) begin
            step(1);
            if (done || busy) seen++;
        end
        chk("no_done_after_reset", 32'(seen), 32'd0);

        step(2);
        $display("Simulation finished: %0d checks, %0d errors", check_cnt, err_cnt);
        $finish;
    end

endmodule
